// File: rtl/clock_display_scan_pkg.sv
// Shared types and constants for the multiplexed HH:MM:SS display scanner.
package clock_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DIV    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2
  } field_t;

  localparam logic [5:0] SEC_LIM  = 6'd60;
  localparam logic [5:0] MIN_LIM  = 6'd60;
  localparam logic [4:0] HOUR_LIM = 5'd24;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

endpackage

// File: rtl/clock_display_scan_if.sv
// Time-of-day input bus and display pin bundle of the display scanner.
interface clock_display_scan_if;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] dig_sel;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  modport master (output sec, min, hour, input dig_sel, seg, dp, frame);
  modport slave  (input sec, min, hour, output dig_sel, seg, dp, frame);
endinterface

// File: rtl/clock_display_scan_seg7_encode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Snapshots SEC/MIN/HOUR once per scan frame, converts to BCD by repeated
// subtraction and drives a 6-digit multiplexed common-anode display.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_display_scan_if.slave  bus
);

  localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0]     cnt_r;
  logic [2:0]        dig_r, dig_next_s;
  logic              tick_s, frame_bnd_s;
  state_t            state_r, state_next_s;
  field_t            field_r, field_next_s;
  logic [5:0]        snap_sec_r, snap_min_r;
  logic [4:0]        snap_hour_r;
  logic [5:0]        rem_r, rem_next_s;
  logic [3:0]        tens_r, tens_next_s;
  logic [5:0][3:0]   work_r, work_next_s, disp_r, eff_bcd_s;
  logic              range_err_r, dp_phase_r, range_err_s, commit_s;
  logic              eff_err_s, eff_phase_s;
  logic [3:0]        eff_digit_s;
  logic [6:0]        enc_seg_s, seg_next_s;
  logic              dp_next_s;
  logic [5:0]        dig_sel_next_s;
  logic [5:0]        dig_sel_r;
  logic [6:0]        seg_r;
  logic              dp_r, frame_r;

  assign tick_s      = (cnt_r == CNT_MAX);
  assign frame_bnd_s = tick_s && (dig_r == DIG_HOUR_TENS);
  assign commit_s    = (state_r == ST_COMMIT);
  assign range_err_s = (snap_sec_r >= SEC_LIM) || (snap_min_r >= MIN_LIM) ||
                       (snap_hour_r >= HOUR_LIM);

  // next digit index, advancing on tick and wrapping after hours tens
  always_comb begin
    dig_next_s = dig_r;
    if (!tick_s) dig_next_s = dig_r;
    else if (dig_r == DIG_HOUR_TENS) dig_next_s = DIG_SEC_ONES;
    else dig_next_s = dig_r + 3'd1;
  end

  // prescaler and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      dig_r <= DIG_SEC_ONES;
    end else begin
      cnt_r <= tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
      dig_r <= dig_next_s;
    end
  end

  // conversion FSM state and working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_LOAD;
      field_r     <= FLD_SEC;
      rem_r       <= 6'd0;
      tens_r      <= 4'd0;
      work_r      <= {24{1'b0}};
      snap_sec_r  <= 6'd0;
      snap_min_r  <= 6'd0;
      snap_hour_r <= 5'd0;
    end else begin
      state_r <= state_next_s;
      field_r <= field_next_s;
      rem_r   <= rem_next_s;
      tens_r  <= tens_next_s;
      work_r  <= work_next_s;
      if (state_r == ST_LOAD) begin
        snap_sec_r  <= bus.sec;
        snap_min_r  <= bus.min;
        snap_hour_r <= bus.hour;
      end
    end
  end

  // conversion FSM next state; a field finishes when the remainder drops below ten
  always_comb begin
    state_next_s = state_r;
    field_next_s = field_r;
    rem_next_s   = rem_r;
    tens_next_s  = tens_r;
    work_next_s  = work_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_bnd_s) state_next_s = ST_LOAD;
        else state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        field_next_s = FLD_SEC;
        rem_next_s   = bus.sec;
        tens_next_s  = 4'd0;
        state_next_s = ST_DIV;
      end
      ST_DIV: begin
        if (rem_r >= 6'd10) begin
          rem_next_s  = rem_r - 6'd10;
          tens_next_s = tens_r + 4'd1;
        end else begin
          tens_next_s = 4'd0;
          case (field_r)
            FLD_SEC: begin
              work_next_s[1:0] = {tens_r, rem_r[3:0]};
              field_next_s     = FLD_MIN;
              rem_next_s       = snap_min_r;
            end
            FLD_MIN: begin
              work_next_s[3:2] = {tens_r, rem_r[3:0]};
              field_next_s     = FLD_HOUR;
              rem_next_s       = {1'b0, snap_hour_r};
            end
            FLD_HOUR: begin
              work_next_s[5:4] = {tens_r, rem_r[3:0]};
              rem_next_s       = 6'd0;
              state_next_s     = ST_COMMIT;
            end
            default: state_next_s = ST_IDLE;
          endcase
        end
      end
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // committed display copy, updated atomically so the scan never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_r      <= {24{1'b0}};
      range_err_r <= 1'b0;
      dp_phase_r  <= 1'b0;
    end else if (commit_s) begin
      disp_r      <= work_r;
      range_err_r <= range_err_s;
      dp_phase_r  <= ~snap_sec_r[0];
    end else begin
      disp_r      <= disp_r;
      range_err_r <= range_err_r;
      dp_phase_r  <= dp_phase_r;
    end
  end

  // values the output registers will show next, bypassing the commit
  always_comb begin
    eff_bcd_s   = commit_s ? work_r : disp_r;
    eff_err_s   = commit_s ? range_err_s : range_err_r;
    eff_phase_s = commit_s ? ~snap_sec_r[0] : dp_phase_r;
    eff_digit_s = 4'd0;
    case (dig_next_s)
      DIG_SEC_ONES:  eff_digit_s = eff_bcd_s[0];
      DIG_SEC_TENS:  eff_digit_s = eff_bcd_s[1];
      DIG_MIN_ONES:  eff_digit_s = eff_bcd_s[2];
      DIG_MIN_TENS:  eff_digit_s = eff_bcd_s[3];
      DIG_HOUR_ONES: eff_digit_s = eff_bcd_s[4];
      DIG_HOUR_TENS: eff_digit_s = eff_bcd_s[5];
      default:       eff_digit_s = 4'd0;
    endcase
  end

  seg7_encode u_seg7_encode (
    .digit (eff_digit_s),
    .seg   (enc_seg_s)
  );

  // segment override, colon and digit enable for the next scan slot
  always_comb begin
    seg_next_s = enc_seg_s;
    if (eff_err_s) seg_next_s = SEG_DASH;
    else if ((LZ_BLANK == 1'b1) && (dig_next_s == DIG_HOUR_TENS) && (eff_digit_s == 4'd0))
      seg_next_s = SEG_BLANK;
    else seg_next_s = enc_seg_s;
    dp_next_s = !(((dig_next_s == DIG_MIN_ONES) || (dig_next_s == DIG_HOUR_ONES)) &&
                  eff_phase_s && !eff_err_s);
    dig_sel_next_s = ~(6'd1 << dig_next_s);
  end

  // registered display pins, updated on scan tick or commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel_r <= 6'h3F;
      seg_r     <= SEG_BLANK;
      dp_r      <= 1'b1;
      frame_r   <= 1'b0;
    end else begin
      frame_r <= commit_s;
      if (tick_s || commit_s) begin
        dig_sel_r <= dig_sel_next_s;
        seg_r     <= seg_next_s;
        dp_r      <= dp_next_s;
      end
    end
  end

  assign bus.dig_sel = dig_sel_r;
  assign bus.seg     = seg_r;
  assign bus.dp      = dp_r;
  assign bus.frame   = frame_r;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed plus randomized check of the display scanner against a time-to-segments model.
module tb_clock_display_scan;

  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  clock_display_scan_if bus0 ();
  clock_display_scan_if bus1 ();

  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  clock_display_scan #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus0.hour = 5'(h); bus0.min = 6'(m); bus0.sec = 6'(s);
    bus1.hour = 5'(h); bus1.min = 6'(m); bus1.sec = 6'(s);
  endtask

  function automatic int exp_seg(input int h, input int m, input int s, input int d, input bit lz);
    int val [6];
    val = '{s % 10, s / 10, m % 10, m / 10, h % 10, h / 10};
    if (s > 59 || m > 59 || h > 23) return 'h3F;
    if (lz && d == 5 && val[5] == 0) return 'h7F;
    return int'(seg_tab[val[d]]);
  endfunction

  function automatic int exp_dp(input int h, input int m, input int s, input int d);
    if (s > 59 || m > 59 || h > 23) return 1;
    return ((d == 2 || d == 4) && (s % 2 == 0)) ? 0 : 1;
  endfunction

  function automatic int digit_of(input logic [5:0] sel);
    for (int i = 0; i < 6; i++) if (sel[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dig_sel0"}, int'(bus0.dig_sel), 'h3F);
    check({tag, "_seg0"},     int'(bus0.seg), 'h7F);
    check({tag, "_dp0"},      int'(bus0.dp), 1);
    check({tag, "_frame0"},   int'(bus0.frame), 0);
    check({tag, "_dig_sel1"}, int'(bus1.dig_sel), 'h3F);
    check({tag, "_frame1"},   int'(bus1.frame), 0);
  endtask

  task automatic wait_frame(input int bound, input string tag);
    int n = 0;
    while (bus0.frame !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frame_seen0"}, int'(bus0.frame), 1);
    check({tag, "_frame_seen1"}, int'(bus1.frame), 1);
  endtask

  task automatic wait_load(input string tag);
    logic [5:0] prev;
    bit found = 1'b0;
    int n = 0;
    prev = bus0.dig_sel;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      found = (bus0.dig_sel == 6'h3E) && (prev != 6'h3E);
      prev  = bus0.dig_sel;
    end
    check({tag, "_load_seen"}, int'(found), 1);
  endtask

  // one full scan after a FRAME pulse: content, colon, order and dwell
  task automatic check_window(input int h, input int m, input int s, input string tag);
    int prev_d = -1;
    int run = 0;
    bit first_run = 1'b1;
    for (int c = 0; c < 6 * SCAN_DIV; c++) begin
      int d;
      d = digit_of(bus0.dig_sel);
      check({tag, "_onehot"}, $countones(~bus0.dig_sel), 1);
      check({tag, "_sel_match"}, int'(bus1.dig_sel), int'(bus0.dig_sel));
      if (c == 1) check({tag, "_frame_1cyc"}, int'(bus0.frame), 0);
      if (d >= 0) begin
        check($sformatf("%s_seg_d%0d", tag, d), int'(bus0.seg), exp_seg(h, m, s, d, 1'b0));
        check($sformatf("%s_lzseg_d%0d", tag, d), int'(bus1.seg), exp_seg(h, m, s, d, 1'b1));
        check($sformatf("%s_dp_d%0d", tag, d), int'(bus0.dp), exp_dp(h, m, s, d));
        check($sformatf("%s_lzdp_d%0d", tag, d), int'(bus1.dp), exp_dp(h, m, s, d));
      end
      if (prev_d >= 0 && d != prev_d) begin
        check({tag, "_walk"}, d, (prev_d + 1) % 6);
        if (!first_run) check({tag, "_dwell"}, run, SCAN_DIV);
        first_run = 1'b0;
        run = 0;
      end
      run++;
      prev_d = d;
      @(negedge clk);
    end
  endtask

  // new inputs sampled at LOAD, then scrambled mid-conversion and restored after FRAME
  task automatic run_frame(input int h, input int m, input int s, input string tag);
    wait_load(tag);
    set_time(h, m, s);
    repeat (2) @(negedge clk);
    set_time(int'($urandom_range(31, 0)), int'($urandom_range(63, 0)), int'($urandom_range(63, 0)));
    wait_frame(40, tag);
    set_time(h, m, s);
    check_window(h, m, s, tag);
  endtask

  initial begin
    int rh, rm, rs;
    set_time(12, 34, 56);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_frame(20, "first");
    check_window(12, 34, 56, "first");

    run_frame(12, 34, 57, "iso57");
    run_frame(24, 0, 0, "rerr");
    run_frame(23, 0, 0, "rerr_clr");
    run_frame(0, 0, 0, "zero");
    run_frame(23, 59, 59, "max");

    // reset while the seconds field is still being divided
    wait_load("mid_rst");
    set_time(23, 59, 59);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    set_time(5, 7, 9);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_frame", int'(bus0.frame), 0);
    end
    rst_n = 1'b1;
    wait_frame(20, "post_rst");
    check_window(5, 7, 9, "post_rst");

    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) begin
        rh = int'($urandom_range(31, 0));
        rm = int'($urandom_range(63, 0));
        rs = int'($urandom_range(63, 0));
      end else begin
        rh = int'($urandom_range(23, 0));
        rm = int'($urandom_range(59, 0));
        rs = int'($urandom_range(59, 0));
      end
      run_frame(rh, rm, rs, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
